if_prefetch: RTL and testbench

//   Instruction-fetch front end feeding the IF/ID register (ir12/pc12) of the 5-stage core.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/if_fifo.sv | 71 +++++++
 rtl/if_prefetch.sv | 92 +++++++++
 tb/tb_if_prefetch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared core types and constants for the instruction-fetch front end.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [PC_W-1:0]    RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small prefetch FIFO of {pc, ir} pairs with flush; the head is read directly from storage.
module if_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [PW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count masks every unwritten entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_q == PW'(gi))) mem_q[gi] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // The fetch credit scheme upstream must never overfill the buffer.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n_i) !(push_i && full_o));

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: drives the sync-read icache, buffers responses, flushes on redirect.
module if_prefetch
  import mips_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               AW       = 9,
  parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [AW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_ir,
  output logic [PC_W-1:0]    id_pc
);

  localparam int PW = $clog2(DEPTH);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            pending_q, pending_d;

  fetch_entry_t    push_data, head;
  logic [PW:0]     count;
  logic            full, empty;
  logic            push, pop;
  logic [PW+1:0]   in_flight;
  logic            credit_ok;

  // A request is only issued if its response is guaranteed a free slot.
  assign in_flight = {1'b0, count} + (PW+2)'(pending_q);
  assign credit_ok = in_flight < (PW+2)'(DEPTH);

  assign imem_en   = reset && !redirect && credit_ok;
  assign imem_addr = fetch_pc_q[AW+1:2];

  assign push      = pending_q && !redirect;
  assign pop       = id_valid && id_ready && !redirect;
  assign push_data = '{pc: pend_pc_q, ir: imem_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = 1'b0;
    if (redirect) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (imem_en) begin
      pend_pc_d  = fetch_pc_q;
      pending_d  = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
    end
  end

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n_i     (reset),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  // An empty buffer presents a NOP bubble, identical to the pipeline flush value.
  assign id_valid = !empty;
  assign id_ir    = id_valid ? head.ir : NOP_INSTR;
  assign id_pc    = id_valid ? head.pc : '0;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: stimulus queues expected PCs, a negedge monitor checks the ID stream.
module tb_if_prefetch;

  localparam int AW = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_q;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [31:0] id_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;
  logic [31:0] exp_q[$];

  if_prefetch #(.DEPTH(4), .AW(AW), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_ir       (id_ir),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  // Icache model: mem[i] = i, one-cycle synchronous read; garbage when not enabled.
  always @(posedge clk) begin
    if (imem_en) imem_q <= {23'b0, imem_addr};
    else         imem_q <= 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] exp_ir(input logic [31:0] pc);
    return (pc >> 2) & 32'h0000_01FF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_imem_en"},  {31'b0, imem_en},  32'h0);
    check({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
    check({tag, "_id_ir"},    id_ir,             32'h0);
    check({tag, "_id_pc"},    id_pc,             32'h0);
  endtask

  // Monitor: compare the head against the scoreboard; retire it when ID accepts.
  always @(negedge clk) begin
    if (reset === 1'b1 && redirect === 1'b0) begin
      if (id_valid) begin
        if (exp_q.size() == 0) begin
          check("head_unexpected", id_pc, 32'hFFFF_FFFF);
        end else begin
          check("head_pc", id_pc, exp_q[0]);
          check("head_ir", id_ir, exp_ir(exp_q[0]));
          if (id_ready) begin
            $display("[TB] pop pc=%h ir=%h", id_pc, id_ir);
            void'(exp_q.pop_front());
            pop_cnt++;
          end
        end
      end else begin
        check("bubble_pc", id_pc, 32'h0);
        check("bubble_ir", id_ir, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int p0;

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    #12;
    check_zero_outputs("reset");

    // Release reset; stream from RESET_PC at one instruction per cycle.
    tick();
    load_seq(32'h0);
    id_ready = 1'b1;
    reset = 1'b1;
    tick();
    check("fill_valid_e0", {31'b0, id_valid}, 32'h0);
    tick();
    check("fill_valid_e1", {31'b0, id_valid}, 32'h1);
    check("fill_first_pc", id_pc, 32'h0);
    p0 = pop_cnt;
    repeat (10) tick();
    check("throughput", 32'(pop_cnt - p0), 32'd10);

    // ID stall: buffer saturates, fetch stops, head stays put (monitor checks head).
    id_ready = 1'b0;
    repeat (10) tick();
    check("stall_imem_en", {31'b0, imem_en}, 32'h0);
    check("stall_valid", {31'b0, id_valid}, 32'h1);
    id_ready = 1'b1;
    repeat (8) tick();

    // Redirect while the FIFO is full.
    id_ready = 1'b0;
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    load_seq(32'h100);
    id_ready = 1'b1;
    #1;
    check("redir_imem_en", {31'b0, imem_en}, 32'h0);
    tick();
    redirect = 1'b0;
    check("redir_valid_t", {31'b0, id_valid}, 32'h0);
    tick();
    check("redir_valid_t1", {31'b0, id_valid}, 32'h0);
    tick();
    check("redir_valid_t2", {31'b0, id_valid}, 32'h1);
    check("redir_pc", id_pc, 32'h100);
    repeat (4) tick();

    // Held redirect, last target wins, unaligned target is aligned.
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    load_seq(32'h200);
    tick();
    redirect_pc = 32'h0000_0103;
    load_seq(32'h100);
    tick();
    redirect = 1'b0;
    #1;
    check("align_imem_en", {31'b0, imem_en}, 32'h1);
    check("align_imem_addr", {23'b0, imem_addr}, 32'h40);
    repeat (6) tick();

    // Address wrap past the top of memory.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    load_seq(32'hFFFF_FFFC);
    tick();
    redirect = 1'b0;
    p0 = pop_cnt;
    repeat (6) tick();
    check("wrap_pops", 32'(pop_cnt - p0), 32'd4);

    // Asynchronous reset mid-stream with redirect asserted.
    #2;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_zero_outputs("midreset");
    tick();
    tick();
    load_seq(32'h0);
    redirect = 1'b0;
    reset = 1'b1;
    tick();
    check("restart_valid_e0", {31'b0, id_valid}, 32'h0);
    tick();
    check("restart_valid_e1", {31'b0, id_valid}, 32'h1);
    check("restart_pc", id_pc, 32'h0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
